// File: rtl/mac_accumulator.sv
// rtl/mac_accumulator.sv - per-neuron product accumulator with bias, ReLU/requantize and argmax
module mac_accumulator #(
  parameter int N_IN  = 784,
  parameter int N_OUT = 10,
  parameter int SHIFT = 8,
  parameter int ACC_W = 32
) (
  input  logic                                                   clk,
  input  logic                                                   rst,
  input  logic                                                   start,
  input  logic signed [15:0]                                     product,
  input  logic                                                   product_valid,
  input  logic signed [15:0]                                     bias,
  output logic [7:0]                                             out_feature,
  output logic signed [ACC_W-1:0]                                out_sum,
  output logic                                                   out_valid,
  output logic [(($clog2(N_OUT) < 1) ? 1 : $clog2(N_OUT))-1:0]   class_idx,
  output logic                                                   class_valid
);

  localparam int CW = $clog2(N_IN);
  localparam int IW = ($clog2(N_OUT) < 1) ? 1 : $clog2(N_OUT);
  localparam logic [ACC_W:0] HALF = (ACC_W+1)'(1) << (SHIFT - 1);

  logic signed [ACC_W-1:0] acc;
  logic [CW-1:0]           cnt;
  logic signed [ACC_W-1:0] sum_r;
  logic                    fin_r;
  logic [IW-1:0]           idx;
  logic [IW-1:0]           best;
  logic signed [ACC_W-1:0] max_r;
  logic                    class_pend;

  logic signed [ACC_W-1:0] prod_ext;
  logic signed [ACC_W-1:0] bias_ext;
  logic                    last_term;
  logic [ACC_W:0]          rounded;
  logic signed [ACC_W:0]   q;
  logic [7:0]              feature_next;
  logic                    take_new;
  logic [IW-1:0]           best_next;
  logic signed [ACC_W-1:0] max_next;
  logic                    wrap;

  assign prod_ext  = {{(ACC_W-16){product[15]}}, product};
  assign bias_ext  = {{(ACC_W-16){bias[15]}}, bias};
  assign last_term = (cnt == CW'(N_IN - 1));
  assign wrap      = (idx == IW'(N_OUT - 1));

  // Requantize: round-half-up shift in ACC_W+1 bits, ReLU, saturate to 8 bits
  always_comb begin
    rounded      = {sum_r[ACC_W-1], sum_r} + HALF;
    q            = $signed(rounded) >>> SHIFT;
    feature_next = 8'd0;
    if (sum_r > 0) begin
      if (|q[ACC_W:8]) feature_next = 8'hff;
      else             feature_next = q[7:0];
    end
  end

  // Argmax candidate: first neuron of a frame always wins, otherwise strictly greater
  always_comb begin
    take_new  = (idx == '0) || (sum_r > max_r);
    best_next = take_new ? idx : best;
    max_next  = take_new ? sum_r : max_r;
  end

  // Accumulate stage: sum N_IN products, fold in bias on the final one
  always_ff @(posedge clk) begin
    if (rst) begin
      acc   <= '0;
      cnt   <= '0;
      sum_r <= '0;
      fin_r <= 1'b0;
    end else if (start) begin
      acc   <= product_valid ? prod_ext : '0;
      cnt   <= product_valid ? CW'(1) : '0;
      fin_r <= 1'b0;
    end else if (product_valid && last_term) begin
      sum_r <= acc + prod_ext + bias_ext;
      acc   <= '0;
      cnt   <= '0;
      fin_r <= 1'b1;
    end else begin
      fin_r <= 1'b0;
      if (product_valid) begin
        acc <= acc + prod_ext;
        cnt <= cnt + CW'(1);
      end
    end
  end

  // Output stage: publish raw sum and requantized feature one edge after sum_r
  always_ff @(posedge clk) begin
    if (rst) begin
      out_sum     <= '0;
      out_feature <= '0;
      out_valid   <= 1'b0;
    end else if (start) begin
      out_valid <= 1'b0;
    end else begin
      out_valid <= fin_r;
      if (fin_r) begin
        out_sum     <= sum_r;
        out_feature <= feature_next;
      end
    end
  end

  // Argmax tracking across the frame; class result announced one edge after the last neuron
  always_ff @(posedge clk) begin
    if (rst) begin
      idx         <= '0;
      best        <= '0;
      max_r       <= '0;
      class_pend  <= 1'b0;
      class_idx   <= '0;
      class_valid <= 1'b0;
    end else if (start) begin
      idx         <= '0;
      best        <= '0;
      max_r       <= '0;
      class_pend  <= 1'b0;
      class_valid <= 1'b0;
    end else begin
      class_valid <= class_pend;
      class_pend  <= fin_r && wrap;
      if (fin_r) begin
        max_r <= max_next;
        best  <= best_next;
        idx   <= wrap ? '0 : idx + IW'(1);
        if (wrap) class_idx <= best_next;
      end
    end
  end

endmodule
